// File: rtl/tmr_timer.sv
// tmr_timer: bus-mapped timer/counter with compare-match restart, sticky interrupt flag and toggle output
module tmr_timer #(
   parameter int tmr_w = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  addr,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        irq,
   input  logic        tmr_in,
   output logic        tmr_out
);
   logic [2:0]       cr;
   logic [tmr_w-1:0] cv;
   logic [tmr_w-1:0] re;
   logic             ir;
   logic [2:0]       sync;
   logic             wr_cr, wr_cv, wr_re, wr_ir, ev, cnt, hit;
   logic             unused_wd;
   assign unused_wd = ^wd[31:tmr_w];
   assign wr_cr = we && addr == 5'h00;
   assign wr_cv = we && addr == 5'h04;
   assign wr_re = we && addr == 5'h08;
   assign wr_ir = we && addr == 5'h0c;
   assign ev    = cr[2] ? sync[1] & ~sync[2] : 1'b1;
   assign cnt   = ev & ~cr[0];
   assign hit   = cnt && cv == re;
   assign irq   = ir & cr[1];
   // register read mux, unlisted addresses read 0
   always_comb
      rd = addr == 5'h00 ? 32'(cr) :
           addr == 5'h04 ? 32'(cv) :
           addr == 5'h08 ? 32'(re) :
           addr == 5'h0c ? 32'(ir) : 32'h0;
   // two-flop synchronizer for tmr_in followed by the edge-detect register
   always_ff @(posedge clk or posedge rstn)
      if (rstn) sync <= '0;
      else sync <= {sync[1:0], tmr_in};
   // control and compare registers
   always_ff @(posedge clk or posedge rstn)
      if (rstn) begin
         cr <= '0;
         re <= '1;
      end else begin
         if (wr_cr) cr <= wd[2:0];
         if (wr_re) re <= wd[tmr_w-1:0];
      end
   // counter, sticky flag and toggle output; a bus load of CV wins, a match wins over clearing the flag
   always_ff @(posedge clk or posedge rstn)
      if (rstn) begin
         cv      <= '0;
         ir      <= 1'b0;
         tmr_out <= 1'b0;
      end else begin
         cv      <= wr_cv ? wd[tmr_w-1:0] : (cr[0] || hit) ? '0 : cnt ? cv + 1'b1 : cv;
         ir      <= hit ? 1'b1 : wr_ir ? wd[0] : ir;
         tmr_out <= tmr_out ^ hit;
      end
endmodule

// File: tb/tb_tmr_timer.sv
// tb_tmr_timer: randomized check of tmr_timer against a cycle-level behavioural model
module tb_tmr_timer;
   logic        clk = 1'b0, rstn = 1'b1, we = 1'b0, tmr_in = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] wd = '0;
   logic [31:0] rd;
   logic        irq, tmr_out;
   int n_chk = 0, n_bad = 0, cyc = 0;
   int m_cr, m_cv, m_re, m_ir, m_out;
   int p1, p2, p3;
   int tin_mode = 0, tin_cnt = 0;

   tmr_timer #(.tmr_w(8)) dut (
      .clk(clk), .rstn(rstn), .addr(addr), .we(we), .wd(wd),
      .rd(rd), .irq(irq), .tmr_in(tmr_in), .tmr_out(tmr_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_cr = 0; m_cv = 0; m_re = 255; m_ir = 0; m_out = 0;
      p1 = 0; p2 = 0; p3 = 0;
   endtask

   function automatic int model_rd(input int a);
      return a == 0 ? m_cr : a == 4 ? m_cv : a == 8 ? m_re : a == 12 ? m_ir : 0;
   endfunction

   // p1..p3 are tmr_in as sampled 1..3 edges ago; a rise sampled at edge j counts at edge j+2
   task automatic model_edge(input bit w, input int a, input int d, input bit t);
      bit ev, cnt, hit;
      ev  = (m_cr & 4) != 0 ? (p2 == 1 && p3 == 0) : 1'b1;
      cnt = ev && (m_cr & 1) == 0;
      hit = cnt && m_cv == m_re;
      p3 = p2; p2 = p1; p1 = int'(t);
      if (w && a == 12) m_ir = d & 1;
      if (hit) begin
         m_ir = 1;
         m_out = 1 - m_out;
      end
      if (w && a == 4) m_cv = d & 255;
      else if ((m_cr & 1) != 0 || hit) m_cv = 0;
      else if (cnt) m_cv = (m_cv + 1) % 256;
      if (w && a == 0) m_cr = d & 7;
      if (w && a == 8) m_re = d & 255;
   endtask

   task automatic step(input bit w, input int a, input int d);
      we = w; addr = a[4:0]; wd = d;
      if (tin_mode == 1) begin
         tin_cnt++;
         if (tin_cnt >= 20) begin tin_cnt = 0; tmr_in = ~tmr_in; end
      end else if (tin_mode == 2) begin
         tin_cnt--;
         if (tin_cnt <= 0) begin tmr_in = ~tmr_in; tin_cnt = $urandom_range(2, 6); end
      end
      #2;
      chk("rd", rd, model_rd(a));
      chk("irq", irq, m_ir & ((m_cr >> 1) & 1));
      chk("tmr_out", tmr_out, m_out);
      @(posedge clk);
      model_edge(w, a, d, tmr_in);
      #1;
      cyc++;
   endtask

   task automatic run(input int n, input int per);
      int last = -1;
      logic po = tmr_out;
      for (int i = 0; i < n; i++) begin
         step(1'b0, 4 * $urandom_range(0, 3), 0);
         if (tmr_out !== po) begin
            if (per > 0 && last >= 0) chk("out_period", cyc - last, per);
            last = cyc;
            po = tmr_out;
         end
      end
   endtask

   initial begin
      int last, nrise, a, d;
      logic prev;
      bit found;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b0;
      addr = 5'h00; #1 chk("rst_cr", rd, 0);
      addr = 5'h04; #1 chk("rst_cv", rd, 0);
      addr = 5'h08; #1 chk("rst_re", rd, 32'hff);
      addr = 5'h0c; #1 chk("rst_ir", rd, 0);
      chk("rst_irq", irq, 0);
      chk("rst_out", tmr_out, 0);
      // internal mode, interrupt enabled, period 81
      step(1, 4, 0); step(1, 8, 'h50); step(1, 12, 0); step(1, 0, 2);
      last = -1; nrise = 0; prev = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (irq && !prev) begin
            if (last >= 0) chk("irq_period", cyc - last, 81);
            last = cyc; nrise++; prev = 1'b1;
            step(1, 12, 0);
         end else begin
            prev = irq;
            step(1'b0, 4 * $urandom_range(0, 3), 0);
         end
      end
      chk("irq_count", nrise >= 35, 1);
      // interrupt masked, tmr_out still toggles every 81 cycles
      step(1, 0, 0);
      run(400, 81);
      // external mode, RE=3, tmr_in period 40 cycles -> match every 160 cycles
      step(1, 4, 0); step(1, 8, 3); step(1, 0, 6);
      tin_mode = 1; tin_cnt = 0;
      run(900, 160);
      // hold in reset via tmr_r, then load CV and move RE below it
      tin_mode = 0;
      step(1, 0, 1);
      repeat (10) step(0, 4, 0);
      step(1, 4, 'h33);
      step(0, 4, 0);
      step(1, 0, 0); step(1, 4, 'h10); step(0, 4, 0);
      step(1, 8, 5);
      run(300, 0);
      // clear the flag in the very cycle of a match
      step(1, 0, 2);
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         if (m_cv == 5) found = 1'b1;
         else step(0, 4, 0);
      end
      chk("race_found", found, 1);
      step(1, 12, 0);
      we = 1'b0; addr = 5'h0c;
      #1 chk("ir_race", rd, 1);
      chk("irq_race", irq, 1);
      // asynchronous reset in the middle of counting
      repeat (3) step(0, 4, 0);
      #1 rstn = 1'b1;
      #1 chk("arst_cv", rd, 0);
      chk("arst_irq", irq, 0);
      chk("arst_out", tmr_out, 0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b0;
      model_reset();
      step(0, 4, 0); step(0, 4, 0);
      // random bus traffic with random tmr_in
      tin_mode = 2; tin_cnt = 3;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            a = $urandom_range(0, 5) == 5 ? $urandom_range(0, 31) : 4 * $urandom_range(0, 3);
            d = $urandom;
            if (a == 0 && $urandom_range(0, 3) != 0) d = d & ~1;
            if ((a == 8 || a == 4) && $urandom_range(0, 1) == 1) d = $urandom_range(0, 20);
            step(1, a, d);
         end else step(0, $urandom_range(0, 15), 0);
      end
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/tmr_timer.md
# tmr_timer

Memory-mapped 8-bit (parameterizable) timer/counter peripheral on the simple register bus. Counts either system clock cycles or rising edges of the external `tmr_in` pin. On a match with a programmable compare value it restarts from zero, sets a sticky interrupt flag and toggles `tmr_out`. It sits beside the other bus peripherals, and its `irq` goes to the interrupt controller.

## Interface
- `tmr_w`, default 8: counter, compare and counter-register width.
- `clk` in 1: clock; all state updates on its rising edge.
- `rstn` in 1: reset rstn, asynchronous, active-high; clock clk.
- `addr` in 5: byte address of the register.
- `we` in 1: write enable; the write occurs on the `clk` edge where `we`=1.
- `wd` in 32: write data.
- `rd` out 32: read data, combinational from `addr`.
- `irq` out 1: interrupt request, level.
- `tmr_in` in 1: external count input, asynchronous to `clk`.
- `tmr_out` out 1: compare-match toggle output.

## Operation
- Register map (unlisted addresses read 0 and ignore writes; unused bits read 0):
  - TMR_CR 0x00: bit2 `tmr_ex` (1 = count `tmr_in` rising edges, 0 = count `clk`), bit1 `tmr_ie` (interrupt enable), bit0 `tmr_r` (1 = counter held at 0, no counting).
  - TMR_CV 0x04: counter value [tmr_w-1:0]; a write loads the counter.
  - TMR_RE 0x08: compare/reload value [tmr_w-1:0].
  - TMR_IR 0x0C: bit0 interrupt flag; a write stores `wd[0]`. Write 0 clears the flag; write 1 sets it.
- Count event:
  - Internal mode: every `clk` cycle.
  - External mode: `tmr_in` passes through a 2-flop synchronizer, then a rising-edge detect gives a one-cycle event.
- On a count event with `tmr_r`=0:
  - If CV == RE: CV←0, IR flag←1, `tmr_out` toggles.
  - Otherwise CV←CV+1, modulo 2^tmr_w. The natural wrap from all-ones to 0 does not set the flag.
- `irq` = IR flag & `tmr_ie`, combinational from registers.
- Priority within one cycle:
  - Bus write to CV beats counting and the match.
  - A match setting the flag beats a bus write clearing TMR_IR in the same cycle, so the flag ends at 1.
  - `tmr_r`=1 forces CV←0 every cycle unless CV is being written.
- RE written below the current CV: the counter runs up to all-ones, wraps to 0, then matches.
- RE=0: a match occurs on every count event.

## Timing
- Reset values: CR=0, CV=0, RE=all-ones, IR=0, `tmr_out`=0, `irq`=0, synchronizer/edge flops=0. `rd` reflects the reset values immediately.
- Register writes take effect on the `clk` edge where `we`=1 and are readable in the next cycle.
- Internal mode: match period = RE+1 cycles. The IR flag and `irq` (if `tmr_ie`=1) go high in the cycle after the edge where CV==RE.
- External mode: latency from a `tmr_in` rising edge to the count event is 3 `clk` edges (2 sync flops + edge register). `tmr_in` high/low times must each be ≥2 `clk` periods.
- `irq` stays high until software clears TMR_IR or clears `tmr_ie`. Clearing `tmr_ie` masks `irq` without clearing the flag.
- Reset asserted mid-count returns all state to reset values asynchronously. Counting resumes from 0 on the first edge after release.

## Test plan
- Reset, then read all registers -> CR=0, CV=0, RE=0xFF, IR=0, `irq`=0, `tmr_out`=0.
- Write CR=0x2 (internal, ie=1), RE=0x50 -> `irq` rises every 81 cycles. Writing TMR_IR=0 drops `irq` next cycle. Run 20000 cycles and count interrupts: ≈246, each with a constant spacing.
- Same as above with `tmr_ie`=0 -> `irq` stays 0 while TMR_IR reads 1 after a match. `tmr_out` toggles every 81 cycles.
- CR=0x6 (external), RE=3, `tmr_in` toggling every 20 cycles -> match every 4 `tmr_in` rising edges (160 cycles). Flag set 3–4 cycles after the 4th edge.
- CR with `tmr_r`=1 -> CV reads 0 continuously. Write CV=0x10 with `tmr_r`=0 -> counting resumes from 0x10. Write RE=0x05 while CV=0x10 -> wrap at 0xFF, then match at 5.
- Clear TMR_IR in the same cycle as a match -> flag reads 1. Assert `rstn` mid-count -> CV=0, `irq`=0 immediately.
